multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the CHARIS datapath. It sequences the fetch, decode/register-read, execute, memory and write-back stages and drives every select and enable consumed by the decode stage (RF_B_sel, RF_WrData_sel, RF_WrEn), the ALU stage, the memory stage and the PC. One instruction is in flight at a time. The block sits beside the datapath and reads only the latched instruction register and the ALU zero flag.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/ctrl_opdecode.sv | 65 ++++++
 rtl/multicycle_ctrl.sv | 118 +++++++++++
 tb/tb_multicycle_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the CHARIS multi-cycle controller.
// The StTrap state only exists when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

    localparam int unsigned ALU_FUNC_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LW    = 6'b000111;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_SB    = 6'b001111;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;

    localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_FUNC_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_FUNC_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_FUNC_W-1:0] ALU_NOT = 4'b0100;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRA = 4'b1000;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLL = 4'b1010;
    localparam logic [ALU_FUNC_W-1:0] ALU_ROL = 4'b1100;
    localparam logic [ALU_FUNC_W-1:0] ALU_ROR = 4'b1101;

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StDec  = 3'd1,
        StExec = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
        , StTrap = 3'd5
`endif
    } state_e;

    typedef enum logic [2:0] {
        ClsRtype, ClsImm, ClsLoad, ClsStore, ClsBr, ClsBrc, ClsIll
    } op_class_e;

    // R-type funcs are 11xxxx with the low nibble naming a real ALU operation.
    function automatic logic func_legal(logic [5:0] func);
        logic ok;
        ok = 1'b0;
        if (func[5:4] == 2'b11) begin
            case (func[3:0])
                ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT,
                ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROL, ALU_ROR: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_ctrl_if;

    logic [31:0]                      Instr;
    logic                             ALU_zero;
    logic                             IR_LdEn;
    logic                             RF_B_sel;
    logic                             RF_WrEn;
    logic                             RF_WrData_sel;
    logic                             ALU_Bin_sel;
    logic [ctrl_pkg::ALU_FUNC_W-1:0]  ALU_func;
    logic                             Mem_WrEn;
    logic                             ByteOp;
    logic                             PC_sel;
    logic                             PC_LdEn;
    logic                             Illegal_Op;

    modport master (
        input  Instr, ALU_zero,
        output IR_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel, ALU_Bin_sel, ALU_func,
               Mem_WrEn, ByteOp, PC_sel, PC_LdEn, Illegal_Op
    );

    modport slave (
        output Instr, ALU_zero,
        input  IR_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel, ALU_Bin_sel, ALU_func,
               Mem_WrEn, ByteOp, PC_sel, PC_LdEn, Illegal_Op
    );

endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational opcode/func decode into instruction class and datapath selects.
module ctrl_opdecode
    import ctrl_pkg::*;
(
    input  logic [5:0]            opcode_i,
    input  logic [5:0]            func_i,
    output op_class_e             op_class_o,
    output logic [ALU_FUNC_W-1:0] alu_func_o,
    output logic                  alu_bin_sel_o,
    output logic                  byte_op_o,
    output logic                  rf_b_sel_o,
    output logic                  br_ne_o
);

    always_comb begin
        op_class_o    = ClsIll;
        alu_func_o    = ALU_ADD;
        alu_bin_sel_o = 1'b0;
        byte_op_o     = 1'b0;
        rf_b_sel_o    = 1'b0;
        br_ne_o       = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                if (func_legal(func_i)) begin
                    op_class_o = ClsRtype;
                    alu_func_o = func_i[3:0];
                end
            end
            OP_LI, OP_ADDI: begin
                op_class_o    = ClsImm;
                alu_bin_sel_o = 1'b1;
            end
            OP_ANDI: begin
                op_class_o    = ClsImm;
                alu_func_o    = ALU_AND;
                alu_bin_sel_o = 1'b1;
            end
            OP_ORI: begin
                op_class_o    = ClsImm;
                alu_func_o    = ALU_OR;
                alu_bin_sel_o = 1'b1;
            end
            OP_LW, OP_LB: begin
                op_class_o    = ClsLoad;
                alu_bin_sel_o = 1'b1;
                byte_op_o     = (opcode_i == OP_LB);
            end
            OP_SW, OP_SB: begin
                op_class_o    = ClsStore;
                alu_bin_sel_o = 1'b1;
                byte_op_o     = (opcode_i == OP_SB);
                rf_b_sel_o    = 1'b1;
            end
            OP_B: op_class_o = ClsBr;
            OP_BEQ, OP_BNE: begin
                op_class_o = ClsBrc;
                alu_func_o = ALU_SUB;
                rf_b_sel_o = 1'b1;
                br_ne_o    = (opcode_i == OP_BNE);
            end
            default: op_class_o = ClsIll;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/DEC/EXEC/MEM/WB sequencer for the CHARIS datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap on undefined codes instead of running them as NOPs.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    multicycle_ctrl_if.master bus
);

    state_e                  state_q;
    op_class_e               op_class;
    logic [ALU_FUNC_W-1:0]   dec_alu_func;
    logic                    dec_bin_sel;
    logic                    dec_byte_op;
    logic                    dec_rf_b_sel;
    logic                    dec_br_ne;
    logic                    unused_instr_bits;

    assign unused_instr_bits = ^bus.Instr[25:6];

    ctrl_opdecode u_opdecode (
        .opcode_i      (bus.Instr[31:26]),
        .func_i        (bus.Instr[5:0]),
        .op_class_o    (op_class),
        .alu_func_o    (dec_alu_func),
        .alu_bin_sel_o (dec_bin_sel),
        .byte_op_o     (dec_byte_op),
        .rf_b_sel_o    (dec_rf_b_sel),
        .br_ne_o       (dec_br_ne)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIf;
        end else begin
            case (state_q)
                StIf:  state_q <= StDec;
                StDec: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    if (op_class == ClsIll) state_q <= StTrap;
                    else                    state_q <= StExec;
`else
                    state_q <= StExec;
`endif
                end
                StExec: begin
                    case (op_class)
                        ClsRtype, ClsImm:  state_q <= StWb;
                        ClsLoad, ClsStore: state_q <= StMem;
                        default:           state_q <= StIf;
                    endcase
                end
                StMem:  state_q <= (op_class == ClsLoad) ? StWb : StIf;
                StWb:   state_q <= StIf;
`ifdef CTRL_ILLEGAL_TRAP_EN
                StTrap: state_q <= StTrap;
`endif
                default: state_q <= StIf;
            endcase
        end
    end

    // Reset gates every output so an aborted instruction cannot write or advance PC.
    always_comb begin
        bus.IR_LdEn       = 1'b0;
        bus.RF_B_sel      = 1'b0;
        bus.RF_WrEn       = 1'b0;
        bus.RF_WrData_sel = 1'b0;
        bus.ALU_Bin_sel   = 1'b0;
        bus.ALU_func      = ALU_ADD;
        bus.Mem_WrEn      = 1'b0;
        bus.ByteOp        = 1'b0;
        bus.PC_sel        = 1'b0;
        bus.PC_LdEn       = 1'b0;
        bus.Illegal_Op    = 1'b0;
        if (!Reset) begin
            case (state_q)
                StIf:  bus.IR_LdEn  = 1'b1;
                StDec: bus.RF_B_sel = dec_rf_b_sel;
                StExec: begin
                    bus.ALU_func    = dec_alu_func;
                    bus.ALU_Bin_sel = dec_bin_sel;
                    bus.ByteOp      = dec_byte_op;
                    case (op_class)
                        ClsBr: begin
                            bus.PC_sel  = 1'b1;
                            bus.PC_LdEn = 1'b1;
                        end
                        ClsBrc: begin
                            bus.PC_sel  = dec_br_ne ? !bus.ALU_zero : bus.ALU_zero;
                            bus.PC_LdEn = 1'b1;
                        end
                        ClsIll:  bus.PC_LdEn = 1'b1;
                        default: ;
                    endcase
                end
                StMem: begin
                    bus.ByteOp = dec_byte_op;
                    if (op_class == ClsStore) begin
                        bus.Mem_WrEn = 1'b1;
                        bus.PC_LdEn  = 1'b1;
                    end
                end
                StWb: begin
                    bus.RF_WrEn       = 1'b1;
                    bus.PC_LdEn       = 1'b1;
                    bus.RF_WrData_sel = (op_class == ClsLoad);
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                StTrap: bus.Illegal_Op = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs queued, checked by a monitor.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       ir;
        logic       rfb;
        logic       binsel;
        logic [3:0] func;
        logic       byteop;
        logic       pcsel;
        logic       pcld;
        logic       rfwe;
        logic       wdsel;
        logic       memwe;
        logic       ill;
    } outs_t;

    typedef struct {
        outs_t v;
        string name;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    exp_t  mon_item;
    outs_t mon_act;

    function automatic outs_t mk(logic ir, logic rfb, logic binsel, logic [3:0] func,
                                 logic byteop, logic pcsel, logic pcld, logic rfwe,
                                 logic wdsel, logic memwe, logic ill);
        outs_t o;
        o.ir = ir; o.rfb = rfb; o.binsel = binsel; o.func = func; o.byteop = byteop;
        o.pcsel = pcsel; o.pcld = pcld; o.rfwe = rfwe; o.wdsel = wdsel;
        o.memwe = memwe; o.ill = ill;
        return o;
    endfunction

    function automatic logic [31:0] ins(logic [5:0] op, logic [5:0] func);
        return {op, 5'd1, 5'd2, 5'd3, 5'd0, func};
    endfunction

    always @(negedge Clk) begin
        if (q.size() != 0) begin
            mon_item = q.pop_front();
            mon_act = mk(bus.IR_LdEn, bus.RF_B_sel, bus.ALU_Bin_sel, bus.ALU_func, bus.ByteOp,
                         bus.PC_sel, bus.PC_LdEn, bus.RF_WrEn, bus.RF_WrData_sel,
                         bus.Mem_WrEn, bus.Illegal_Op);
            n_checks++;
            if (mon_act === mon_item.v) n_pass++;
            else $display("FAIL %s: got %b required %b (ir rfb bin func byte pcsel pcld rfwe wdsel memwe ill)",
                          mon_item.name, mon_act, mon_item.v);
        end
    end

    task automatic cyc(input logic rst, input logic [31:0] instr, input logic z,
                       input outs_t e, input string nm);
        exp_t it;
        @(posedge Clk);
        #1;
        Reset        = rst;
        bus.Instr    = instr;
        bus.ALU_zero = z;
        it.v    = e;
        it.name = nm;
        q.push_back(it);
    endtask

    initial begin
        outs_t z0, ifv, wb;
        logic [31:0] i_add, i_sub, i_ori, i_lw, i_sb, i_beq, i_bne, i_b, i_sw, i_li, i_andi;
        logic [31:0] i_bad, i_badf;

        bus.Instr    = '0;
        bus.ALU_zero = 1'b0;
        z0  = '0;
        ifv = mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        wb  = mk(0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 0);
        i_add  = ins(6'b100000, 6'b110000);
        i_sub  = ins(6'b100000, 6'b110001);
        i_ori  = ins(6'b110011, 6'b000000);
        i_lw   = ins(6'b000111, 6'b000000);
        i_sb   = ins(6'b001111, 6'b000000);
        i_beq  = ins(6'b000000, 6'b000000);
        i_bne  = ins(6'b000001, 6'b000000);
        i_b    = ins(6'b111111, 6'b000000);
        i_sw   = ins(6'b011111, 6'b000000);
        i_li   = ins(6'b111000, 6'b000000);
        i_andi = ins(6'b110010, 6'b000000);
        i_bad  = ins(6'b101010, 6'b000000);
        i_badf = ins(6'b100000, 6'b000111);

        cyc(1, '0, 0, z0, "reset0");
        cyc(1, '0, 0, z0, "reset1");

        cyc(0, i_add, 0, ifv, "add_if");
        cyc(0, i_add, 0, z0, "add_dec");
        cyc(0, i_add, 0, z0, "add_exec");
        cyc(0, i_add, 0, wb, "add_wb");

        cyc(0, i_sub, 0, ifv, "sub_if");
        cyc(0, i_sub, 0, z0, "sub_dec");
        cyc(0, i_sub, 0, mk(0, 0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0), "sub_exec");
        cyc(0, i_sub, 0, wb, "sub_wb");

        cyc(0, i_ori, 0, ifv, "ori_if");
        cyc(0, i_ori, 0, z0, "ori_dec");
        cyc(0, i_ori, 0, mk(0, 0, 1, 4'h3, 0, 0, 0, 0, 0, 0, 0), "ori_exec");
        cyc(0, i_ori, 0, wb, "ori_wb");

        cyc(0, i_lw, 0, ifv, "lw_if");
        cyc(0, i_lw, 0, z0, "lw_dec");
        cyc(0, i_lw, 0, mk(0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0), "lw_exec");
        cyc(0, i_lw, 0, z0, "lw_mem");
        cyc(0, i_lw, 0, mk(0, 0, 0, 4'h0, 0, 0, 1, 1, 1, 0, 0), "lw_wb");

        cyc(0, i_sb, 0, ifv, "sb_if");
        cyc(0, i_sb, 0, mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0), "sb_dec");
        cyc(0, i_sb, 0, mk(0, 0, 1, 4'h0, 1, 0, 0, 0, 0, 0, 0), "sb_exec");
        cyc(0, i_sb, 0, mk(0, 0, 0, 4'h0, 1, 0, 1, 0, 0, 1, 0), "sb_mem");

        cyc(0, i_beq, 1, ifv, "beq_z1_if");
        cyc(0, i_beq, 1, mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0), "beq_z1_dec");
        cyc(0, i_beq, 1, mk(0, 0, 0, 4'h1, 0, 1, 1, 0, 0, 0, 0), "beq_z1_exec");
        cyc(0, i_bne, 1, ifv, "bne_z1_if");
        cyc(0, i_bne, 1, mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0), "bne_z1_dec");
        cyc(0, i_bne, 1, mk(0, 0, 0, 4'h1, 0, 0, 1, 0, 0, 0, 0), "bne_z1_exec");
        cyc(0, i_bne, 0, ifv, "bne_z0_if");
        cyc(0, i_bne, 0, mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0), "bne_z0_dec");
        cyc(0, i_bne, 0, mk(0, 0, 0, 4'h1, 0, 1, 1, 0, 0, 0, 0), "bne_z0_exec");
        cyc(0, i_beq, 0, ifv, "beq_z0_if");
        cyc(0, i_beq, 0, mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0), "beq_z0_dec");
        cyc(0, i_beq, 0, mk(0, 0, 0, 4'h1, 0, 0, 1, 0, 0, 0, 0), "beq_z0_exec");

        cyc(0, i_b, 0, ifv, "b_if");
        cyc(0, i_b, 0, z0, "b_dec");
        cyc(0, i_b, 0, mk(0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0), "b_exec");

        // sw aborted by a 3-cycle reset while in MEM
        cyc(0, i_sw, 0, ifv, "sw_if");
        cyc(0, i_sw, 0, mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0), "sw_dec");
        cyc(0, i_sw, 0, mk(0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0), "sw_exec");
        cyc(1, i_sw, 0, z0, "sw_rst_mem");
        cyc(1, i_sw, 0, z0, "sw_rst2");
        cyc(1, i_sw, 0, z0, "sw_rst3");
        cyc(0, i_li, 0, ifv, "rel_if");
        cyc(0, i_li, 0, z0, "li_dec");
        cyc(0, i_li, 0, mk(0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0), "li_exec");
        cyc(0, i_li, 0, wb, "li_wb");

        cyc(0, i_bad, 0, ifv, "bad_if");
        cyc(0, i_bad, 0, z0, "bad_dec");
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++)
            cyc(0, i_bad, 0, mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1), "trap_hold");
        cyc(1, i_bad, 0, z0, "trap_rst");
`else
        cyc(0, i_bad, 0, mk(0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0), "bad_nop_exec");
        cyc(0, i_badf, 0, ifv, "badf_if");
        cyc(0, i_badf, 0, z0, "badf_dec");
        cyc(0, i_badf, 0, mk(0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0), "badf_nop_exec");
`endif
        cyc(0, i_andi, 0, ifv, "andi_if");
        cyc(0, i_andi, 0, z0, "andi_dec");
        cyc(0, i_andi, 0, mk(0, 0, 1, 4'h2, 0, 0, 0, 0, 0, 0, 0), "andi_exec");
        cyc(0, i_andi, 0, wb, "andi_wb");

        repeat (2) @(posedge Clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
